// File: rtl/stopwatch_cs.sv
// stopwatch_cs: SS.CC BCD stopwatch counting rising edges of a ms tick, with start/stop/clear control
module stopwatch_cs #(
  parameter int TICKS_PER_CS = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        clear_i,
  output logic [15:0] time_o,
  output logic        running_o,
  output logic [1:0]  state_o,
  output logic        wrap_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
  localparam logic [9:0] LAST = 10'(TICKS_PER_CS - 1);
  state_t state_q, state_d;
  logic tick_q, wrap_q, wrap_d;
  logic [9:0] pre_q, pre_d;
  logic [3:0] c0_q, c0_d, c1_q, c1_d, s0_q, s0_d, s1_q, s1_d;
  logic cnt, adv, k0, k1, k2;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      pre_q   <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_i;
      wrap_q  <= wrap_d;
      pre_q   <= pre_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
    end
  end
  // counting follows the pre-edge state, so a coincident stop still counts and a coincident start does not
  always_comb begin
    state_d = clear_i ? IDLE :
              stop_i  ? (state_q == RUN ? PAUSE : state_q) :
              (start_i && state_q != RUN) ? RUN : state_q;
    cnt    = state_q == RUN && tick_i && !tick_q && !clear_i;
    adv    = cnt && pre_q == LAST;
    k0     = adv && c0_q == 4'd9;
    k1     = k0 && c1_q == 4'd9;
    k2     = k1 && s0_q == 4'd9;
    wrap_d = k2 && s1_q == 4'd5;
    pre_d  = (clear_i || adv) ? '0 : cnt ? pre_q + 10'd1 : pre_q;
    c0_d   = (clear_i || k0) ? '0 : adv ? c0_q + 4'd1 : c0_q;
    c1_d   = (clear_i || k1) ? '0 : k0 ? c1_q + 4'd1 : c1_q;
    s0_d   = (clear_i || k2) ? '0 : k1 ? s0_q + 4'd1 : s0_q;
    s1_d   = (clear_i || wrap_d) ? '0 : k2 ? s1_q + 4'd1 : s1_q;
  end
  assign time_o    = {s1_q, s0_q, c1_q, c0_q};
  assign running_o = state_q == RUN;
  assign state_o   = state_q;
  assign wrap_o    = wrap_q;
endmodule

// File: tb/tb_stopwatch_cs.sv
// tb_stopwatch_cs: directed vector table plus hand sequences for stopwatch_cs
module tb_stopwatch_cs;
  logic clk_i = 1'b0, rst_i = 1'b1, tick_i = 1'b0, start_i = 1'b0, stop_i = 1'b0, clear_i = 1'b0;
  logic tick_f = 1'b0;
  logic [15:0] time_o, time_f;
  logic running_o, running_f, wrap_o, wrap_f;
  logic [1:0] state_o, state_f;
  int n_cmp = 0, n_err = 0;
  stopwatch_cs dut (
    .clk_i(clk_i), .rst_i(rst_i), .tick_i(tick_i), .start_i(start_i), .stop_i(stop_i),
    .clear_i(clear_i), .time_o(time_o), .running_o(running_o), .state_o(state_o), .wrap_o(wrap_o)
  );
  // short prescale so the full minute rollover fits in a reasonable run
  stopwatch_cs #(.TICKS_PER_CS(2)) u_fast (
    .clk_i(clk_i), .rst_i(rst_i), .tick_i(tick_f), .start_i(start_i), .stop_i(stop_i),
    .clear_i(clear_i), .time_o(time_f), .running_o(running_f), .state_o(state_f), .wrap_o(wrap_f)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic st, sp, cl, tk;
    logic [1:0] es;
    logic [15:0] et;
  } vec_t;
  vec_t tbl[12];
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic ticks(input int n, input int h);
    for (int i = 0; i < n; i++) begin
      tick_i = 1'b1;
      repeat (h) cycle();
      tick_i = 1'b0;
      repeat (h) cycle();
    end
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) cycle();
    rst_i = 1'b0;
    cycle();
  endtask
  task automatic pulse_start();
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
  endtask
  initial begin
    tbl[0]  = '{0, 0, 0, 0, 2'd0, 16'h0};
    tbl[1]  = '{0, 1, 0, 0, 2'd0, 16'h0};
    tbl[2]  = '{1, 0, 0, 0, 2'd1, 16'h0};
    tbl[3]  = '{1, 0, 0, 0, 2'd1, 16'h0};
    tbl[4]  = '{0, 1, 0, 0, 2'd2, 16'h0};
    tbl[5]  = '{0, 1, 0, 0, 2'd2, 16'h0};
    tbl[6]  = '{1, 0, 0, 0, 2'd1, 16'h0};
    tbl[7]  = '{0, 0, 1, 0, 2'd0, 16'h0};
    tbl[8]  = '{1, 0, 0, 0, 2'd1, 16'h0};
    tbl[9]  = '{1, 1, 1, 0, 2'd0, 16'h0};
    tbl[10] = '{1, 0, 0, 1, 2'd1, 16'h0};
    tbl[11] = '{0, 0, 0, 0, 2'd1, 16'h0};
    repeat (2) cycle();
    chk("rst_time", time_o, 16'h0);
    chk("rst_state", state_o, 2'd0);
    chk("rst_running", running_o, 1'b0);
    chk("rst_wrap", wrap_o, 1'b0);
    rst_i = 1'b0;
    cycle();
    for (int i = 0; i < 12; i++) begin
      {start_i, stop_i, clear_i, tick_i} = {tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].tk};
      cycle();
      chk($sformatf("vec%0d_state", i), state_o, tbl[i].es);
      chk($sformatf("vec%0d_running", i), running_o, tbl[i].es == 2'd1);
      chk($sformatf("vec%0d_time", i), time_o, tbl[i].et);
    end
    {start_i, stop_i, clear_i, tick_i} = 4'b0;
    // first centisecond and its latency
    do_reset();
    pulse_start();
    ticks(9, 4);
    chk("cs1_before", time_o, 16'h0000);
    tick_i = 1'b1;
    cycle();
    chk("cs1_latency", time_o, 16'h0001);
    chk("cs1_running", running_o, 1'b1);
    chk("cs1_state", state_o, 2'd1);
    repeat (3) cycle();
    tick_i = 1'b0;
    repeat (4) cycle();
    // pause keeps time and partial prescale
    do_reset();
    pulse_start();
    ticks(55, 4);
    chk("pause_55", time_o, 16'h0005);
    stop_i = 1'b1;
    cycle();
    stop_i = 1'b0;
    chk("pause_state", state_o, 2'd2);
    for (int i = 0; i < 30; i += 10) begin
      ticks(10, 4);
      chk($sformatf("pause_hold%0d", i), time_o, 16'h0005);
    end
    pulse_start();
    ticks(45, 4);
    chk("resume_total", time_o, 16'h0010);
    // rollover on the short-prescale instance
    do_reset();
    pulse_start();
    for (int i = 0; i < 11999; i++) begin
      tick_f = 1'b1;
      cycle();
      tick_f = 1'b0;
      cycle();
    end
    chk("pre_wrap_time", time_f, 16'h5999);
    chk("pre_wrap_flag", wrap_f, 1'b0);
    tick_f = 1'b1;
    cycle();
    chk("wrap_time", time_f, 16'h0000);
    chk("wrap_flag", wrap_f, 1'b1);
    tick_f = 1'b0;
    cycle();
    chk("wrap_one_cycle", wrap_f, 1'b0);
    // stop coincident with the counting tick, then clear coincident with a tick
    do_reset();
    pulse_start();
    ticks(9, 4);
    tick_i = 1'b1;
    stop_i = 1'b1;
    cycle();
    stop_i = 1'b0;
    chk("stop_tick_time", time_o, 16'h0001);
    chk("stop_tick_state", state_o, 2'd2);
    repeat (3) cycle();
    tick_i = 1'b0;
    repeat (4) cycle();
    pulse_start();
    ticks(9, 4);
    chk("clr_pre_time", time_o, 16'h0001);
    tick_i = 1'b1;
    clear_i = 1'b1;
    cycle();
    clear_i = 1'b0;
    chk("clr_tick_time", time_o, 16'h0000);
    chk("clr_tick_state", state_o, 2'd0);
    chk("clr_tick_wrap", wrap_o, 1'b0);
    tick_i = 1'b0;
    cycle();
    pulse_start();
    ticks(9, 4);
    chk("clr_prescale_zero", time_o, 16'h0000);
    ticks(1, 4);
    chk("clr_prescale_one", time_o, 16'h0001);
    // asynchronous reset mid-run
    do_reset();
    pulse_start();
    ticks(3420, 1);
    chk("mid_run_time", time_o, 16'h0342);
    rst_i = 1'b1;
    #1;
    chk("async_time", time_o, 16'h0000);
    chk("async_state", state_o, 2'd0);
    chk("async_running", running_o, 1'b0);
    chk("async_wrap", wrap_o, 1'b0);
    tick_i = 1'b1;
    repeat (2) cycle();
    rst_i = 1'b0;
    cycle();
    tick_i = 1'b0;
    cycle();
    ticks(20, 4);
    chk("post_rst_time", time_o, 16'h0000);
    chk("post_rst_state", state_o, 2'd0);
    // long-held tick counts once
    do_reset();
    pulse_start();
    ticks(9, 4);
    tick_i = 1'b1;
    repeat (50) cycle();
    chk("held_time", time_o, 16'h0001);
    tick_i = 1'b0;
    cycle();
    ticks(9, 4);
    chk("held_once", time_o, 16'h0001);
    ticks(1, 4);
    chk("held_next", time_o, 16'h0002);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
